// File: rtl/decode_step_if.sv
// Fetch->decode->execute handshake and decoded-instruction bus for decode_step.
// slave is the decode side; master is the surrounding pipeline.
interface decode_step_if #(
    parameter int unsigned XLEN = 32
);
    logic            enable_step_i;
    logic            fetch_finished_i;
    logic [31:0]     instruction_i;
    logic [XLEN-1:0] pc_i;
    logic            execute_working_info_i;

    logic            decode_working_info_o;
    logic            decode_finished_o;
    logic [XLEN-1:0] pc_o;
    logic [3:0]      instr_class_o;
    logic [4:0]      rd_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic            rd_we_o;
    logic [2:0]      funct3_o;
    logic            funct7b5_o;
    logic [XLEN-1:0] imm_o;
    logic            illegal_o;

    modport slave (
        input  enable_step_i, fetch_finished_i, instruction_i, pc_i, execute_working_info_i,
        output decode_working_info_o, decode_finished_o, pc_o, instr_class_o,
               rd_o, rs1_o, rs2_o, rd_we_o, funct3_o, funct7b5_o, imm_o, illegal_o
    );

    modport master (
        output enable_step_i, fetch_finished_i, instruction_i, pc_i, execute_working_info_i,
        input  decode_working_info_o, decode_finished_o, pc_o, instr_class_o,
               rd_o, rs1_o, rs2_o, rd_we_o, funct3_o, funct7b5_o, imm_o, illegal_o
    );
endinterface

// File: rtl/decode_step.sv
// RV32I decode stage: latches one instruction from fetch, decodes it, and holds
// the registered result until execute consumes it.
module decode_step #(
    parameter int unsigned XLEN = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    decode_step_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_VALID
    } state_e;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_LUI     = 4'd1,
        C_AUIPC   = 4'd2,
        C_JAL     = 4'd3,
        C_JALR    = 4'd4,
        C_BRANCH  = 4'd5,
        C_LOAD    = 4'd6,
        C_STORE   = 4'd7,
        C_OPIMM   = 4'd8,
        C_OP      = 4'd9,
        C_FENCE   = 4'd10,
        C_SYSTEM  = 4'd11
    } class_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_e          state_q, state_d;
    logic            capture;
    logic            load_out;

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_lat_q;

    logic [XLEN-1:0] pc_out_q;
    class_e          cls_q, cls_d;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic            rd_we_q, rd_we_d;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            illegal_q, illegal_d;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            writes_rd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enable low freezes everything, including consumption by execute.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_out = 1'b0;
        if (bus.enable_step_i) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.fetch_finished_i) begin
                        capture = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    load_out = 1'b1;
                    state_d  = S_VALID;
                end
                S_VALID: begin
                    if (!bus.execute_working_info_i) begin
                        if (bus.fetch_finished_i) begin
                            capture = 1'b1;
                            state_d = S_DECODE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign opcode = instr_q[6:0];
    assign f3     = instr_q[14:12];
    assign f7     = instr_q[31:25];

    always_comb begin
        cls_d     = C_ILLEGAL;
        imm_d     = '0;
        illegal_d = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI: begin
                cls_d     = C_LUI;
                imm_d     = {instr_q[31:12], 12'b0};
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                cls_d     = C_AUIPC;
                imm_d     = {instr_q[31:12], 12'b0};
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                cls_d     = C_JAL;
                imm_d     = {{(XLEN-20){instr_q[31]}}, instr_q[19:12], instr_q[20],
                             instr_q[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                cls_d     = C_JALR;
                imm_d     = {{(XLEN-11){instr_q[31]}}, instr_q[30:20]};
                writes_rd = 1'b1;
                illegal_d = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                cls_d     = C_BRANCH;
                imm_d     = {{(XLEN-12){instr_q[31]}}, instr_q[7], instr_q[30:25],
                             instr_q[11:8], 1'b0};
                illegal_d = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                cls_d     = C_LOAD;
                imm_d     = {{(XLEN-11){instr_q[31]}}, instr_q[30:20]};
                writes_rd = 1'b1;
                illegal_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                cls_d     = C_STORE;
                imm_d     = {{(XLEN-11){instr_q[31]}}, instr_q[30:25], instr_q[11:7]};
                illegal_d = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                cls_d     = C_OPIMM;
                imm_d     = {{(XLEN-11){instr_q[31]}}, instr_q[30:20]};
                writes_rd = 1'b1;
                illegal_d = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                            ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
            end
            OPC_OP: begin
                cls_d     = C_OP;
                writes_rd = 1'b1;
                illegal_d = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                            ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
            end
            OPC_FENCE:  cls_d = C_FENCE;
            OPC_SYSTEM: cls_d = C_SYSTEM;
            default:    illegal_d = 1'b1;
        endcase
        if (illegal_d) begin
            cls_d = C_ILLEGAL;
            imm_d = '0;
        end
        rd_we_d = writes_rd && !illegal_d && (instr_q[11:7] != 5'd0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q  <= '0;
            pc_lat_q <= '0;
        end else if (capture) begin
            instr_q  <= bus.instruction_i;
            pc_lat_q <= bus.pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_out_q   <= '0;
            cls_q      <= C_ILLEGAL;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_we_q    <= 1'b0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            imm_q      <= '0;
            illegal_q  <= 1'b0;
        end else if (load_out) begin
            pc_out_q   <= pc_lat_q;
            cls_q      <= cls_d;
            rd_q       <= instr_q[11:7];
            rs1_q      <= instr_q[19:15];
            rs2_q      <= instr_q[24:20];
            rd_we_q    <= rd_we_d;
            funct3_q   <= f3;
            funct7b5_q <= instr_q[30];
            imm_q      <= imm_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.decode_working_info_o = (state_q != S_IDLE);
    assign bus.decode_finished_o     = (state_q == S_VALID);
    assign bus.pc_o                  = pc_out_q;
    assign bus.instr_class_o         = cls_q;
    assign bus.rd_o                  = rd_q;
    assign bus.rs1_o                 = rs1_q;
    assign bus.rs2_o                 = rs2_q;
    assign bus.rd_we_o               = rd_we_q;
    assign bus.funct3_o              = funct3_q;
    assign bus.funct7b5_o            = funct7b5_q;
    assign bus.imm_o                 = imm_q;
    assign bus.illegal_o             = illegal_q;

endmodule

// File: tb/tb_decode_step.sv
// Randomized and directed bench for decode_step against an arithmetic RV32I
// decode model.
module tb_decode_step;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    decode_step_if #(.XLEN(32)) bus ();

    decode_step #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Immediates built from weighted bit fields rather than bit splicing.
    function automatic void model(input logic [31:0] w, output logic [3:0] cls,
                                  output logic [31:0] imm, output logic we,
                                  output logic ill);
        int op, f3, f7, rd, v, ival;
        op   = int'(w[6:0]);
        f3   = int'(w[14:12]);
        f7   = int'(w[31:25]);
        rd   = int'(w[11:7]);
        ival = (w[31] ? -2048 : 0) + int'(w[30:20]);
        v    = 0;
        ill  = 1'b0;
        cls  = 4'd0;
        case (op)
            'h37: begin cls = 4'd1; v = int'(w & 32'hFFFFF000); end
            'h17: begin cls = 4'd2; v = int'(w & 32'hFFFFF000); end
            'h6F: begin
                cls = 4'd3;
                v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096
                    + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            'h67: begin cls = 4'd4; v = ival; ill = (f3 != 0); end
            'h63: begin
                cls = 4'd5;
                v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048
                    + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                ill = (f3 == 2) || (f3 == 3);
            end
            'h03: begin cls = 4'd6; v = ival; ill = (f3 == 3) || (f3 >= 6); end
            'h23: begin
                cls = 4'd7;
                v = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
                ill = (f3 > 2);
            end
            'h13: begin
                cls = 4'd8; v = ival;
                ill = ((f3 == 1) && (f7 != 0)) || ((f3 == 5) && (f7 != 0) && (f7 != 32));
            end
            'h33: begin
                cls = 4'd9;
                ill = !((f7 == 0) || (f7 == 32)) || ((f7 == 32) && (f3 != 0) && (f3 != 5));
            end
            'h0F: cls = 4'd10;
            'h73: cls = 4'd11;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            cls = 4'd0;
            v   = 0;
        end
        imm = 32'(v);
        we  = !ill && (rd != 0) && (cls inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9});
    endfunction

    task automatic check_fields(input string tag, input logic [31:0] w, input logic [31:0] pc);
        logic [3:0]  cls;
        logic [31:0] imm;
        logic        we, ill;
        model(w, cls, imm, we, ill);
        check({tag, ".class"}, 32'(bus.instr_class_o), 32'(cls));
        check({tag, ".imm"}, bus.imm_o, imm);
        check({tag, ".rd_we"}, 32'(bus.rd_we_o), 32'(we));
        check({tag, ".illegal"}, 32'(bus.illegal_o), 32'(ill));
        check({tag, ".rd"}, 32'(bus.rd_o), 32'(w[11:7]));
        check({tag, ".rs1"}, 32'(bus.rs1_o), 32'(w[19:15]));
        check({tag, ".rs2"}, 32'(bus.rs2_o), 32'(w[24:20]));
        check({tag, ".funct3"}, 32'(bus.funct3_o), 32'(w[14:12]));
        check({tag, ".funct7b5"}, 32'(bus.funct7b5_o), 32'(w[30]));
        check({tag, ".pc"}, bus.pc_o, pc);
    endtask

    // Expects the DUT in IDLE; leaves it in IDLE with outputs still held.
    task automatic run_one(input string tag, input logic [31:0] w, input logic [31:0] pc,
                           input int stall);
        bus.fetch_finished_i = 1'b1;
        bus.instruction_i    = w;
        bus.pc_i             = pc;
        tick();
        check({tag, ".dec_work"}, 32'(bus.decode_working_info_o), 32'd1);
        check({tag, ".dec_fin"}, 32'(bus.decode_finished_o), 32'd0);
        bus.fetch_finished_i       = 1'b0;
        bus.instruction_i          = $urandom;
        bus.execute_working_info_i = (stall > 0);
        tick();
        check({tag, ".val_fin"}, 32'(bus.decode_finished_o), 32'd1);
        check({tag, ".val_work"}, 32'(bus.decode_working_info_o), 32'd1);
        check_fields(tag, w, pc);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, ".stall_fin"}, 32'(bus.decode_finished_o), 32'd1);
            check({tag, ".stall_pc"}, bus.pc_o, pc);
        end
        bus.execute_working_info_i = 1'b0;
        tick();
        check({tag, ".done_fin"}, 32'(bus.decode_finished_o), 32'd0);
        check({tag, ".done_work"}, 32'(bus.decode_working_info_o), 32'd0);
        check({tag, ".done_pc"}, bus.pc_o, pc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".work"}, 32'(bus.decode_working_info_o), 32'd0);
        check({tag, ".fin"}, 32'(bus.decode_finished_o), 32'd0);
        check({tag, ".pc"}, bus.pc_o, 32'd0);
        check({tag, ".class"}, 32'(bus.instr_class_o), 32'd0);
        check({tag, ".imm"}, bus.imm_o, 32'd0);
        check({tag, ".rd"}, 32'(bus.rd_o), 32'd0);
        check({tag, ".rd_we"}, 32'(bus.rd_we_o), 32'd0);
        check({tag, ".illegal"}, 32'(bus.illegal_o), 32'd0);
    endtask

    initial begin
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] w;
        logic [31:0] pc;

        bus.enable_step_i          = 1'b1;
        bus.fetch_finished_i       = 1'b0;
        bus.instruction_i          = '0;
        bus.pc_i                   = '0;
        bus.execute_working_info_i = 1'b0;

        #3;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;

        run_one("addi", 32'h00500093, 32'h80000000, 0);
        check("addi.k_class", 32'(bus.instr_class_o), 32'd8);
        check("addi.k_rd", 32'(bus.rd_o), 32'd1);
        check("addi.k_rs1", 32'(bus.rs1_o), 32'd0);
        check("addi.k_imm", bus.imm_o, 32'd5);
        check("addi.k_we", 32'(bus.rd_we_o), 32'd1);
        check("addi.k_pc", bus.pc_o, 32'h80000000);

        run_one("sw", 32'h0020A423, 32'h00001000, 0);
        check("sw.k_class", 32'(bus.instr_class_o), 32'd7);
        check("sw.k_imm", bus.imm_o, 32'd8);
        check("sw.k_we", 32'(bus.rd_we_o), 32'd0);

        run_one("beq", 32'hFE000EE3, 32'h00001004, 1);
        check("beq.k_class", 32'(bus.instr_class_o), 32'd5);
        check("beq.k_imm", bus.imm_o, 32'hFFFFFFFC);

        run_one("lui", 32'h123452B7, 32'h00001008, 0);
        check("lui.k_class", 32'(bus.instr_class_o), 32'd1);
        check("lui.k_imm", bus.imm_o, 32'h12345000);
        check("lui.k_rd", 32'(bus.rd_o), 32'd5);

        run_one("ill0", 32'h00000000, 32'h0000100C, 0);
        check("ill0.k_ill", 32'(bus.illegal_o), 32'd1);
        check("ill0.k_class", 32'(bus.instr_class_o), 32'd0);
        check("ill0.k_we", 32'(bus.rd_we_o), 32'd0);

        run_one("illop", 32'h40001033, 32'h00001010, 0);
        check("illop.k_ill", 32'(bus.illegal_o), 32'd1);
        check("illop.k_class", 32'(bus.instr_class_o), 32'd0);
        check("illop.k_we", 32'(bus.rd_we_o), 32'd0);

        // Execute stall with a second instruction pending from fetch.
        bus.fetch_finished_i = 1'b1;
        bus.instruction_i    = 32'h00500093;
        bus.pc_i             = 32'h00002000;
        tick();
        bus.instruction_i          = 32'h123452B7;
        bus.pc_i                   = 32'h00002004;
        bus.execute_working_info_i = 1'b1;
        tick();
        check_fields("stallA", 32'h00500093, 32'h00002000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.fin", 32'(bus.decode_finished_o), 32'd1);
            check("stall.work", 32'(bus.decode_working_info_o), 32'd1);
            check("stall.pc", bus.pc_o, 32'h00002000);
            check("stall.imm", bus.imm_o, 32'd5);
        end
        bus.execute_working_info_i = 1'b0;
        tick();
        check("rel.fin", 32'(bus.decode_finished_o), 32'd0);
        check("rel.work", 32'(bus.decode_working_info_o), 32'd1);
        check("rel.pc", bus.pc_o, 32'h00002000);
        bus.fetch_finished_i = 1'b0;
        tick();
        check("stallB.fin", 32'(bus.decode_finished_o), 32'd1);
        check_fields("stallB", 32'h123452B7, 32'h00002004);
        tick();
        check("stallB.idle", 32'(bus.decode_working_info_o), 32'd0);

        // Asynchronous reset while in DECODE.
        bus.fetch_finished_i = 1'b1;
        bus.instruction_i    = 32'h0020A423;
        bus.pc_i             = 32'h00003000;
        tick();
        bus.fetch_finished_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        tick();
        check_all_zero("rst_held");
        rst = 1'b0;
        run_one("post_rst", 32'h00500093, 32'h00003100, 0);

        // Enable gating: disabled in IDLE ignores fetch, disabled in VALID freezes.
        bus.enable_step_i    = 1'b0;
        bus.fetch_finished_i = 1'b1;
        bus.instruction_i    = 32'h123452B7;
        bus.pc_i             = 32'h00004000;
        tick();
        check("en_idle.work", 32'(bus.decode_working_info_o), 32'd0);
        bus.enable_step_i = 1'b1;
        tick();
        bus.fetch_finished_i = 1'b0;
        tick();
        check_fields("en_valid", 32'h123452B7, 32'h00004000);
        bus.enable_step_i    = 1'b0;
        bus.fetch_finished_i = 1'b1;
        bus.instruction_i    = 32'h0020A423;
        bus.pc_i             = 32'h00004100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_off.fin", 32'(bus.decode_finished_o), 32'd1);
            check("en_off.pc", bus.pc_o, 32'h00004000);
        end
        bus.fetch_finished_i = 1'b0;
        bus.enable_step_i    = 1'b1;
        tick();
        check("en_on.fin", 32'(bus.decode_finished_o), 32'd0);
        check("en_on.work", 32'(bus.decode_working_info_o), 32'd0);
        check("en_on.pc", bus.pc_o, 32'h00004000);

        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
            pc = $urandom & 32'hFFFFFFFC;
            run_one("rand", w, pc, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_step.md
# decode_step

Second pipeline stage, directly downstream of the fetch step. Accepts one 32-bit RV32I instruction and its PC per handshake, registers them, and decodes them into register indices, a sign-extended immediate, an instruction class and an illegal flag for the execute step. Drives the working-info signal that stalls fetch while decode holds an instruction execute has not yet consumed.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `enable_step_i` in 1: stage enable. When low, state and all outputs freeze.
- `fetch_finished_i` in 1: fetch has a valid instruction on `instruction_i`/`pc_i`.
- `instruction_i` in 32: instruction word from fetch.
- `pc_i` in 32: address of `instruction_i`.
- `execute_working_info_i` in 1: execute busy. Decode must hold its outputs while this is high.
- `decode_working_info_o` out 1: decode holds an instruction. Fetch stalls on this.
- `decode_finished_o` out 1: decoded outputs are valid.
- `pc_o` out 32: PC of the decoded instruction.
- `instr_class_o` out 4: class code. 0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP, 10 FENCE, 11 SYSTEM.
- `rd_o`, `rs1_o`, `rs2_o` out 5 each: register indices.
- `rd_we_o` out 1: the instruction writes `rd`.
- `funct3_o` out 3: instruction bits [14:12].
- `funct7b5_o` out 1: instruction bit 30.
- `imm_o` out 32: sign-extended immediate.
- `illegal_o` out 1: instruction is not legal RV32I.

## Operation
- State machine with three states: IDLE, DECODE, VALID. Reset state is IDLE.
- **IDLE**
  - On `enable_step_i && fetch_finished_i`: latch `instruction_i` and `pc_i`, go to DECODE.
  - Otherwise stay in IDLE.
- **DECODE**
  - Combinationally decode the latched word.
  - On the next edge, register all decoded outputs and go to VALID.
- **VALID**
  - `decode_finished_o`=1.
  - If `execute_working_info_i`=0 at an edge, the instruction is consumed.
    - If `fetch_finished_i`=1 on that same edge: latch the new instruction and go to DECODE (back-to-back).
    - Otherwise go to IDLE.
  - If `execute_working_info_i`=1: stay in VALID with all outputs stable.
- `decode_working_info_o` = 1 in DECODE and VALID, 0 in IDLE.
- `fetch_finished_i` is ignored in DECODE, and in VALID unless that edge consumes the instruction.
- **Immediate formats**, all sign-extended from bit 31:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R, FENCE and SYSTEM produce `imm_o`=0.
- **Register fields**
  - `rd_o`/`rs1_o`/`rs2_o` always carry bits [11:7]/[19:15]/[24:20], whatever the format.
  - `rd_we_o`=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, but only when `rd_o`≠0 and the instruction is legal.
- **Illegal** when any of the following hold:
  - bits[1:0]≠2'b11;
  - opcode not in the 11 classes;
  - JALR with funct3≠0;
  - BRANCH with funct3 010 or 011;
  - LOAD with funct3 011, 110 or 111;
  - STORE with funct3>010;
  - OP with funct7 not 0000000/0100000, or funct7=0100000 with funct3 not 000/101;
  - OPIMM with funct3=001 and funct7≠0, or funct3=101 and funct7 not 0000000/0100000.
- **On illegal**: `illegal_o`=1, `instr_class_o`=0, `rd_we_o`=0, `imm_o`=0. The handshake proceeds normally.

## Timing
- **Reset**: immediate, no clock needed. State goes to IDLE and every output is 0, including `pc_o` and `decode_working_info_o`.
  - Reset in DECODE or VALID drops the held instruction.
  - The first edge after release samples IDLE.
- **Latency**: instruction captured at edge N; outputs valid with `decode_finished_o`=1 after edge N+1.
- **Throughput**: one instruction per 2 cycles when execute never stalls.
- **Outputs**: all registered. They change only on the DECODE→VALID edge or on reset.
  - Outputs stay stable after consumption until the next DECODE→VALID edge.
  - `decode_finished_o` falls on the edge after consumption.
- **`enable_step_i` low**: no captures and no transitions, including consumption. It takes priority over every handshake.

## Test plan
- **ADDI**: reset, then `0x00500093` with `pc_i`=0x80000000 and execute idle.
  - Two edges after capture: class 8, `rd_o`=1, `rs1_o`=0, `imm_o`=5, `rd_we_o`=1, `pc_o`=0x80000000.
  - `decode_working_info_o` high for exactly 2 cycles.
- **Immediate formats**, each checked for class, immediate and write enable:
  - `0x0020A423` (sw x2,8(x1)): class 7, `imm_o`=8, `rd_we_o`=0.
  - `0xFE000EE3` (beq -4): class 5, `imm_o`=0xFFFFFFFC.
  - `0x123452B7` (lui x5): class 1, `imm_o`=0x12345000, `rd_o`=5.
- **Illegal encodings**, each giving `illegal_o`=1, class 0, `rd_we_o`=0, with `decode_finished_o` still asserted:
  - `0x00000000`
  - `0x40001033` (funct7=0100000, funct3=001)
- **Execute stall**: hold `execute_working_info_i`=1 for 3 cycles in VALID while `fetch_finished_i`=1.
  - Outputs unchanged and `decode_working_info_o`=1.
  - The second instruction is not captured until the release edge, then appears 1 edge later.
- **Reset mid-operation**: assert `rst_i` asynchronously in DECODE.
  - All outputs go to 0 immediately.
  - After release, a new `0x00500093` decodes with normal 2-edge latency.
- **Enable gating**: drop `enable_step_i` in VALID with execute idle.
  - State and outputs hold.
  - Consumption occurs on the first edge after re-enable.
